// File: rtl/heli_pkg.sv
// Shared widths, colours, frame FSM encodings and the pixel record for the plot sink.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package heli_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COLOR_W-1:0] COL_RED   = 3'b100;
  localparam logic [COLOR_W-1:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One buffered pixel; packed so it maps straight onto an 18-bit FIFO word.
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_plot_sink_if.sv
// Pixel stream from a sprite drawer plus the plot port towards the vga_adapter.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates in_en; the plot side has no backpressure.
// Ports: master = drawer/bench side, slave = pixel_plot_sink side.
interface pixel_plot_sink_if;
  import heli_pkg::*;

  logic [X_W-1:0]     in_x;
  logic [Y_W-1:0]     in_y;
  logic [COLOR_W-1:0] in_color;
  logic               in_en;
  logic               in_done;
  logic               in_ready;
  logic [X_W-1:0]     plot_x;
  logic [Y_W-1:0]     plot_y;
  logic [COLOR_W-1:0] plot_color;
  logic               plot;

  modport master (
    output in_x, in_y, in_color, in_en, in_done,
    input  in_ready, plot_x, plot_y, plot_color, plot
  );

  modport slave (
    input  in_x, in_y, in_color, in_en, in_done,
    output in_ready, plot_x, plot_y, plot_color, plot
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous DEPTH x W FIFO with registered occupancy count.
// Latency: a word written at edge N is visible on dout after edge N (show-ahead).
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clock, reset, push, pop, din, dout, full, empty, fill.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (fill == FULL_CNT);
  assign empty   = (fill == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; the wider fill count tells full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_plot_sink.sv
// Buffers drawer pixels and replays them to the vga plot port; flags heli collisions; reports frame done.
// Latency: pixel accepted at edge N is plotted after edge N+1 when it is at the FIFO head.
// Backpressure: in_ready = FIFO not full (registered fill, no bypass); plot side drains one pixel per clock.
// Ports: clock, reset, bus (slave: in_* stream, plot_* port), heli_x/heli_y, clear_hit, hit, frame_done, fill.
module pixel_plot_sink
  import heli_pkg::*;
#(
  parameter int                 DEPTH     = 16,
  parameter int                 HELI_W    = 8,
  parameter int                 HELI_H    = 5,
  parameter logic [COLOR_W-1:0] HIT_COLOR = COL_RED
) (
  input  logic                   clock,
  input  logic                   reset,
  pixel_plot_sink_if.slave       bus,
  input  logic [X_W-1:0]         heli_x,
  input  logic [Y_W-1:0]         heli_y,
  input  logic                   clear_hit,
  output logic                   hit,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] fill
);

  pixel_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       pop_go;
  logic       in_box;
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;
  state_t     state;

  assign bus.in_ready = !fifo_full;
  assign accept       = bus.in_en && bus.in_ready;
  assign pop_go       = !fifo_empty;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pixel_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (pop_go),
    .din   ({bus.in_x, bus.in_y, bus.in_color}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  // Plot register: coordinates hold their last value while the FIFO is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.plot_x     <= '0;
      bus.plot_y     <= '0;
      bus.plot_color <= '0;
      bus.plot       <= 1'b0;
    end else if (pop_go) begin
      bus.plot_x     <= head.x;
      bus.plot_y     <= head.y;
      bus.plot_color <= head.color;
      bus.plot       <= 1'b1;
    end else begin
      bus.plot       <= 1'b0;
    end
  end

  // Box upper bounds carry one extra bit so a box near the screen edge does not wrap to 0.
  assign x_end  = {1'b0, heli_x} + (X_W+1)'(HELI_W);
  assign y_end  = {1'b0, heli_y} + (Y_W+1)'(HELI_H);
  assign in_box = (bus.in_color == HIT_COLOR)
               && (bus.in_x >= heli_x) && ({1'b0, bus.in_x} < x_end)
               && (bus.in_y >= heli_y) && ({1'b0, bus.in_y} < y_end);

  // Sticky hit; a new collision in the same cycle as clear_hit keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  hit <= 1'b0;
    else if (accept && in_box)  hit <= 1'b1;
    else if (clear_hit)         hit <= 1'b0;
  end

  // Frame FSM: DONE only once the drawer is done, the FIFO is empty and nothing is arriving.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.in_done) begin
            state <= ST_IDLE;
          end else if ((fill == '0) && !accept) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.in_done) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
          end else if (accept) begin
            state      <= ST_DRAIN;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: scoreboarded plot stream, full/backpressure, hit box, frame done, reset.
// Latency: n/a.
// Backpressure: bench retries a pixel until in_ready, bounded by a cycle budget.
module tb_pixel_plot_sink;
  import heli_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] heli_x;
  logic [6:0] heli_y;
  logic       clear_hit;
  logic       hit, frame_done, hit2, frame_done2;
  logic [4:0] fill;
  logic [1:0] fill2;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  pixel_t q1[$];
  pixel_t q2[$];
  pixel_t e1, e2;

  always #5 clock = ~clock;

  pixel_plot_sink_if bus ();
  pixel_plot_sink_if bus2 ();

  pixel_plot_sink #(.DEPTH(16)) dut (
    .clock (clock), .reset (reset), .bus (bus),
    .heli_x (heli_x), .heli_y (heli_y), .clear_hit (clear_hit),
    .hit (hit), .frame_done (frame_done), .fill (fill)
  );

  pixel_plot_sink #(.DEPTH(2)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2),
    .heli_x (heli_x), .heli_y (heli_y), .clear_hit (clear_hit),
    .hit (hit2), .frame_done (frame_done2), .fill (fill2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every plot strobe must match the oldest accepted pixel.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.plot === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut_spurious_plot", 32'(bus.plot), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut_plot_pixel", 32'({bus.plot_x, bus.plot_y, bus.plot_color}), 32'(e1));
      end
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b0 && bus2.plot === 1'b1) begin
      if (q2.size() == 0) begin
        check("dut2_spurious_plot", 32'(bus2.plot), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("dut2_plot_pixel", 32'({bus2.plot_x, bus2.plot_y, bus2.plot_color}), 32'(e2));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present a pixel, wait for in_ready (bounded), and return #1 after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int n = 0;
    bus.in_x = x; bus.in_y = y; bus.in_color = c; bus.in_en = 1'b1;
    if (bus.in_ready !== 1'b1) stalls++;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    if (bus.in_ready === 1'b1) begin
      q1.push_back(pixel_t'{x, y, c});
      cyc(1);
    end else begin
      check("dut_send_timeout", 32'(bus.in_ready), 32'd1);
    end
    bus.in_en = 1'b0;
  endtask

  task automatic send2(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int n = 0;
    bus2.in_x = x; bus2.in_y = y; bus2.in_color = c; bus2.in_en = 1'b1;
    while (bus2.in_ready !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    if (bus2.in_ready === 1'b1) begin
      q2.push_back(pixel_t'{x, y, c});
      cyc(1);
    end else begin
      check("dut2_send_timeout", 32'(bus2.in_ready), 32'd1);
    end
    bus2.in_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; heli_x = 8'd40; heli_y = 7'd30; clear_hit = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_color = '0; bus.in_en = 1'b0; bus.in_done = 1'b0;
    bus2.in_x = '0; bus2.in_y = '0; bus2.in_color = '0; bus2.in_en = 1'b0; bus2.in_done = 1'b0;

    // Reset state
    #1;
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_plot_x", 32'(bus.plot_x), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst2_state", 32'({hit2, frame_done2, fill2}), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Passthrough: accepted at edge N, plotted after N+1, then plot drops and coords hold
    send(8'd10, 7'd20, COL_WHITE);
    check("pass_not_yet", 32'(bus.plot), 32'd0);
    check("pass_fill1", 32'(fill), 32'd1);
    cyc(1);
    check("pass_plot", 32'(bus.plot), 32'd1);
    check("pass_x", 32'(bus.plot_x), 32'd10);
    check("pass_y", 32'(bus.plot_y), 32'd20);
    cyc(1);
    check("pass_plot_drop", 32'(bus.plot), 32'd0);
    check("pass_x_hold", 32'(bus.plot_x), 32'd10);

    // 17 back-to-back pixels: one pop per clock keeps fill at 1, in_ready never drops
    stalls = 0;
    for (int i = 0; i < 17; i++) send(8'(i), 7'(i + 1), (i == 3) ? COL_BLACK : 3'(i));
    check("b2b_no_stall", 32'(stalls), 32'd0);
    check("b2b_fill_steady", 32'(fill), 32'd1);
    cyc(3);
    check("b2b_drained", 32'(q1.size()), 32'd0);
    check("b2b_fill0", 32'(fill), 32'd0);

    // Depth-2 build with the read side held off: full blocks the third pixel until it drains
    force dut2.pop_go = 1'b0;
    send2(8'd1, 7'd2, COL_WHITE);
    send2(8'd3, 7'd4, COL_RED);
    check("full_fill2", 32'(fill2), 32'd2);
    check("full_in_ready", 32'(bus2.in_ready), 32'd0);
    fork
      send2(8'd5, 7'd6, COL_WHITE);
      begin
        cyc(2);
        check("full_hold_ready", 32'(bus2.in_ready), 32'd0);
        check("full_hold_fill", 32'(fill2), 32'd2);
        release dut2.pop_go;
      end
    join
    cyc(4);
    check("full_drained", 32'(q2.size()), 32'd0);

    // Hit box: heli (40,30) covers x 40..47, y 30..34
    send(8'd47, 7'd34, COL_RED);
    check("hit_corner", 32'(hit), 32'd1);
    clear_hit = 1'b1; cyc(1); clear_hit = 1'b0;
    check("hit_cleared", 32'(hit), 32'd0);
    send(8'd48, 7'd34, COL_RED);
    check("hit_x_outside", 32'(hit), 32'd0);
    send(8'd47, 7'd35, COL_RED);
    check("hit_y_outside", 32'(hit), 32'd0);
    send(8'd39, 7'd30, COL_RED);
    check("hit_left_outside", 32'(hit), 32'd0);
    send(8'd41, 7'd31, COL_WHITE);
    check("hit_white", 32'(hit), 32'd0);
    clear_hit = 1'b1;
    send(8'd40, 7'd30, COL_RED);
    clear_hit = 1'b0;
    check("hit_set_beats_clear", 32'(hit), 32'd1);
    clear_hit = 1'b1; cyc(1); clear_hit = 1'b0;

    // Box at the screen edge must not wrap
    heli_x = 8'd250; heli_y = 7'd125;
    send(8'd249, 7'd127, COL_RED);
    check("edge_left_miss", 32'(hit), 32'd0);
    send(8'd255, 7'd127, COL_RED);
    check("edge_hit", 32'(hit), 32'd1);
    clear_hit = 1'b1; cyc(1); clear_hit = 1'b0;
    heli_x = 8'd40; heli_y = 7'd30;
    cyc(3);
    check("hit_drained", 32'(q1.size()), 32'd0);

    // Frame done: 30 pixels then in_done; frame_done one cycle after last plot
    for (int i = 0; i < 30; i++) send(8'(100 + i), 7'(i), COL_WHITE);
    bus.in_done = 1'b1;
    check("fd_low_busy", 32'(frame_done), 32'd0);
    cyc(1);
    check("fd_last_plot", 32'(bus.plot), 32'd1);
    check("fd_not_yet", 32'(frame_done), 32'd0);
    cyc(1);
    check("fd_rise", 32'(frame_done), 32'd1);
    check("fd_plot_idle", 32'(bus.plot), 32'd0);
    send(8'd1, 7'd1, COL_WHITE);
    check("fd_reenter_drain", 32'(frame_done), 32'd0);
    cyc(2);
    check("fd_redone", 32'(frame_done), 32'd1);
    bus.in_done = 1'b0;
    cyc(1);
    check("fd_drop", 32'(frame_done), 32'd0);

    // Reset mid-stream with fill = 5 and hit set
    force dut.pop_go = 1'b0;
    send(8'd40, 7'd30, COL_RED);
    for (int i = 0; i < 4; i++) send(8'(i), 7'(i), COL_WHITE);
    check("pre_rst_fill", 32'(fill), 32'd5);
    check("pre_rst_hit", 32'(hit), 32'd1);
    release dut.pop_go;
    cyc(1);
    check("pre_rst_plot", 32'(bus.plot), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_plot", 32'(bus.plot), 32'd0);
    check("midrst_fill", 32'(fill), 32'd0);
    check("midrst_hit", 32'(hit), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    q1.delete();
    cyc(2);
    reset = 1'b0;
    cyc(5);
    check("post_rst_plot", 32'(bus.plot), 32'd0);
    check("post_rst_fill", 32'(fill), 32'd0);

    check("end_q1_empty", 32'(q1.size()), 32'd0);
    check("end_q2_empty", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
